// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: pixel-clock enable in, coordinates/syncs/strobes out.
interface vga_timing_gen_if;
  logic       ce;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic       hsync;
  logic       vsync;
  logic       display_on;
  logic       line_start;
  logic       frame_start;
  logic [9:0] frame_count;

  modport master (
    input  ce,
    output hpos, vpos, hsync, vsync, display_on, line_start, frame_start, frame_count
  );

  modport slave (
    output ce,
    input  hpos, vpos, hsync, vsync, display_on, line_start, frame_start, frame_count
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster generator: h/v counters, frame counter and registered
// decodes that line up with the counter values they describe.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit H_POL     = 1'b0,
  parameter bit V_POL     = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  vga_timing_gen_if.master vga
);
  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_totals
      $error("vga_timing_gen: H_TOTAL/V_TOTAL must not exceed 1024");
    end
  endgenerate

  localparam logic [9:0]  H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
  // 11-bit bounds so a sync ending exactly at 1024 does not wrap to zero
  localparam logic [10:0] HS_BEG = 11'(H_VISIBLE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEG = 11'(V_VISIBLE + V_FP);
  localparam logic [10:0] VS_END = 11'(V_VISIBLE + V_FP + V_SYNC);
  localparam logic [10:0] H_VIS  = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS  = 11'(V_VISIBLE);

  logic [9:0] h_q, v_q, fc_q;
  logic [9:0] h_nxt, v_nxt, fc_nxt;
  logic       hs_q, vs_q, de_q, ls_q, fs_q;
  logic       hs_nxt, vs_nxt, de_nxt, ls_nxt, fs_nxt;

  always_comb begin
    h_nxt  = h_q;
    v_nxt  = v_q;
    fc_nxt = fc_q;
    if (vga.ce) begin
      if (h_q == H_LAST) begin
        h_nxt = '0;
        if (v_q == V_LAST) begin
          v_nxt  = '0;
          fc_nxt = fc_q + 10'd1;
        end else begin
          v_nxt = v_q + 10'd1;
        end
      end else begin
        h_nxt = h_q + 10'd1;
      end
    end
  end

  // Decode the state being loaded so each flag matches the counters it sits beside.
  always_comb begin
    hs_nxt = (({1'b0, h_nxt} >= HS_BEG) && ({1'b0, h_nxt} < HS_END)) ? H_POL : ~H_POL;
    vs_nxt = (({1'b0, v_nxt} >= VS_BEG) && ({1'b0, v_nxt} < VS_END)) ? V_POL : ~V_POL;
    de_nxt = ({1'b0, h_nxt} < H_VIS) && ({1'b0, v_nxt} < V_VIS);
    ls_nxt = (h_nxt == '0);
    fs_nxt = (h_nxt == '0) && (v_nxt == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q  <= '0;
      v_q  <= '0;
      fc_q <= '0;
      hs_q <= ~H_POL;
      vs_q <= ~V_POL;
      de_q <= 1'b1;
      ls_q <= 1'b1;
      fs_q <= 1'b1;
    end else begin
      h_q  <= h_nxt;
      v_q  <= v_nxt;
      fc_q <= fc_nxt;
      hs_q <= hs_nxt;
      vs_q <= vs_nxt;
      de_q <= de_nxt;
      ls_q <= ls_nxt;
      fs_q <= fs_nxt;
    end
  end

  assign vga.hpos        = h_q;
  assign vga.vpos        = v_q;
  assign vga.frame_count = fc_q;
  assign vga.hsync       = hs_q;
  assign vga.vsync       = vs_q;
  assign vga.display_on  = de_q;
  assign vga.line_start  = ls_q;
  assign vga.frame_start = fs_q;
endmodule
